// File: rtl/bcd_updown_counter_7seg.sv
// bcd_updown_counter_7seg: synchronised hit-edge BCD up/down counter with 7-seg decode; rev 1.0
// Optional macro HIT_DEBOUNCE_EN adds a DEB_CYCLES stability filter on the synchronised hit.
`default_nettype none

module bcd_updown_counter_7seg #(
  parameter int DIGITS         = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hit,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  wrap
);

  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, evt_q, evt_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d;
  logic lvl;
  logic carry;
  logic [3:0] nib;

`ifdef HIT_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // The level only follows s2 after it has differed for DEB_CYCLES consecutive clocks.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (s2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign lvl = deb_level_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign lvl        = s2_q;
`endif

  always_comb begin
    s1_d  = hit;
    s2_d  = s1_q;
    s3_d  = lvl;
    evt_d = s3_q & ~lvl;
  end

  // Load wins over an event; the digit loop ripples carry/borrow within one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    carry  = 1'b1;
    nib    = 4'd0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        nib = load_val[4*i +: 4];
        cnt_d[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
      end
    end else if (evt_q && en) begin
      for (int i = 0; i < DIGITS; i++) begin
        nib = cnt_q[4*i +: 4];
        if (carry) begin
          if (up_dn) begin
            if (nib == 4'd9) begin
              cnt_d[4*i +: 4] = 4'd0;
            end else begin
              cnt_d[4*i +: 4] = nib + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              cnt_d[4*i +: 4] = 4'd9;
            end else begin
              cnt_d[4*i +: 4] = nib - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      evt_q  <= 1'b0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      evt_q  <= evt_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign seg[7*g +: 7] = (SEG_ACTIVE_LOW != 0) ? ~seg_decode(cnt_q[4*g +: 4])
                                                 :  seg_decode(cnt_q[4*g +: 4]);
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_counter_7seg.sv
// tb_bcd_updown_counter_7seg: vector table, corner sequences and random ops vs a decimal model; rev 1.0
`default_nettype none

module tb_bcd_updown_counter_7seg;
  localparam int DIGITS = 4;
  localparam int MAXV   = 10000;
`ifdef HIT_DEBOUNCE_EN
  localparam int HOLD = 24;
`else
  localparam int HOLD = 4;
`endif

  logic        clk, reset, hit, en, up_dn, load;
  logic [15:0] load_val, cnt;
  logic [27:0] seg;
  logic        wrap;

  bcd_updown_counter_7seg #(.DIGITS(DIGITS), .SEG_ACTIVE_LOW(1), .DEB_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .hit(hit), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .cnt(cnt), .seg(seg), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wrap_total = 0;
  int model_v = 0;
  logic [6:0] seg_tab [10];

  always @(negedge clk) if (wrap === 1'b1) wrap_total <= wrap_total + 1;

  typedef struct {
    logic [15:0] lv;
    logic        e;
    logic        u;
    logic [15:0] exp_cnt;
    int          exp_wrap;
  } vec_t;
  vec_t vecs [9];

  function automatic int bcd_val(input logic [15:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] seg_exp(input int v);
    logic [27:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = ~seg_tab[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int v);
    check_val({name, "_cnt"}, 32'(cnt), 32'(to_bcd(v)));
    check_val({name, "_seg"}, 32'(seg), 32'(seg_exp(v)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    model_v = bcd_val(v);
  endtask

  task automatic hit_pulse();
    hit = 1'b0;
    repeat (HOLD) tick();
    hit = 1'b1;
    repeat (HOLD + 2) tick();
  endtask

  // Applies one event and advances the decimal model; returns the expected wrap count.
  task automatic do_hit(input logic e, input logic u, output int exp_w);
    en = e;
    up_dn = u;
    exp_w = 0;
    hit_pulse();
    if (e) begin
      if (u) begin
        if (model_v == MAXV - 1) exp_w = 1;
        model_v = (model_v + 1) % MAXV;
      end else begin
        if (model_v == 0) exp_w = 1;
        model_v = (model_v + MAXV - 1) % MAXV;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, ew;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vecs[0] = '{16'h0099, 1'b1, 1'b1, 16'h0100, 0};
    vecs[1] = '{16'h9999, 1'b1, 1'b1, 16'h0000, 1};
    vecs[2] = '{16'h0000, 1'b1, 1'b0, 16'h9999, 1};
    vecs[3] = '{16'h1000, 1'b1, 1'b0, 16'h0999, 0};
    vecs[4] = '{16'h00AF, 1'b0, 1'b1, 16'h0099, 0};
    vecs[5] = '{16'h1234, 1'b1, 1'b1, 16'h1235, 0};
    vecs[6] = '{16'h0909, 1'b1, 1'b0, 16'h0908, 0};
    vecs[7] = '{16'hFFFF, 1'b1, 1'b0, 16'h9998, 0};
    vecs[8] = '{16'h0A0B, 1'b1, 1'b1, 16'h0910, 0};

    reset = 1'b0; hit = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
    for (int i = 0; i < 6; i++) begin
      hit = ~hit;
      tick();
    end
    check_val("reset_cnt", 32'(cnt), 32'h0);
    check_val("reset_wrap", 32'(wrap), 32'h0);
    check_val("reset_seg", 32'(seg), 32'h8102040);
    hit = 1'b1;
    tick();
    reset = 1'b1;
    repeat (HOLD + 4) tick();
    check_state("after_release", 0);

    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].lv);
      w0 = wrap_total;
      do_hit(vecs[i].e, vecs[i].u, ew);
      check_val($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      check_val($sformatf("vec%0d_seg", i), 32'(seg), 32'(seg_exp(bcd_val(vecs[i].exp_cnt))));
      check_val($sformatf("vec%0d_wrap", i), 32'(wrap_total - w0), 32'(vecs[i].exp_wrap));
    end

`ifndef HIT_DEBOUNCE_EN
    // Exact latency: falling hit before edge k, count visible after edge k+3.
    do_load(16'h0041);
    en = 1'b1; up_dn = 1'b1;
    hit = 1'b0;
    repeat (3) tick();
    check_val("latency_early", 32'(cnt), 32'h0041);
    tick();
    check_val("latency_k3", 32'(cnt), 32'h0042);
    hit = 1'b1;
    repeat (6) tick();

    do_load(16'h9999);
    hit = 1'b0;
    repeat (3) tick();
    check_val("wrap_before", 32'(wrap), 32'h0);
    tick();
    check_val("wrap_cnt", 32'(cnt), 32'h0000);
    check_val("wrap_high", 32'(wrap), 32'h1);
    tick();
    check_val("wrap_one_cycle", 32'(wrap), 32'h0);
    hit = 1'b1;
    repeat (6) tick();

    // Load sampled on the same edge that would consume the event.
    do_load(16'h0500);
    hit = 1'b0;
    repeat (3) tick();
    load_val = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    check_val("load_vs_evt", 32'(cnt), 32'h1234);
    repeat (5) tick();
    check_val("evt_dropped", 32'(cnt), 32'h1234);
    hit = 1'b1;
    repeat (6) tick();
`endif

    do_load(16'h1234);
    for (int i = 0; i < 5; i++) do_hit(1'b0, 1'b1, ew);
    check_state("en_low_5hits", 1234);

    do_load(16'h0777);
    en = 1'b1; up_dn = 1'b1;
    hit = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_val("async_reset_cnt", 32'(cnt), 32'h0);
    check_val("async_reset_wrap", 32'(wrap), 32'h0);
    #3;
    reset = 1'b1;
    repeat (HOLD + 4) tick();
    check_val("held_low_release", 32'(cnt), 32'h0);
    hit = 1'b1;
    repeat (HOLD + 4) tick();
    check_state("rise_no_count", 0);
    model_v = 0;

`ifdef HIT_DEBOUNCE_EN
    do_load(16'h0010);
    en = 1'b1; up_dn = 1'b1;
    hit = 1'b0;
    repeat (10) tick();
    hit = 1'b1;
    repeat (40) tick();
    check_val("glitch10", 32'(cnt), 32'h0010);
    hit = 1'b0;
    repeat (20) tick();
    hit = 1'b1;
    repeat (40) tick();
    check_val("pulse20", 32'(cnt), 32'h0011);
`endif

    do_load(16'h9998);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_load(16'($urandom));
        check_state($sformatf("rnd%0d_load", i), model_v);
      end else begin
        w0 = wrap_total;
        do_hit(1'($urandom_range(0, 5) != 0), 1'($urandom), ew);
        check_state($sformatf("rnd%0d", i), model_v);
        check_val($sformatf("rnd%0d_wrap", i), 32'(wrap_total - w0), 32'(ew));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
